// File: rtl/edge_strobe_sync.sv
// Purpose : synchronize + debounce async level `a`, strobe on each qualified edge,
//           capture `b` into a one-entry valid/ready slice, count edges, flag overflow.
// Latency : strobe/capture visible after edge SYNC_STAGES+DEBOUNCE from first high sample.
// Backpr. : `c_ready` low with `c_valid` high drops new captures and sets sticky `ovf`.
// Option  : define EDGE_STROBE_BOTH_EDGES_EN to also qualify falling transitions.
module edge_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int W           = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  (* CLOCK = 0 *)
  input  logic             a,
  input  logic [W-1:0]     b,
  output logic             strb,
  output logic [W-1:0]     c,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ovf
);

  // Debounce counter only needs to reach DEBOUNCE-1; keep at least one bit.
  localparam int            DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DB_W-1:0]        r_db_cnt;
  logic [DB_W-1:0]        w_db_cnt_nxt;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic                   r_stable_d;

  logic                   w_edge;
  logic                   w_load;

  logic                   r_strb;
  logic [W-1:0]           r_c;
  logic                   r_c_valid;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic                   r_ovf;

  // Shift `a` through the synchronizer chain; `a` is treated purely as data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Debounce FSM state, counter and stable level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_db_cnt   <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
      r_stable   <= w_stable_nxt;
      r_stable_d <= r_stable;
    end
  end

  // Next-state: count consecutive samples that differ from the stable level,
  // adopt the new level once DEBOUNCE of them have been seen in a row.
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_stable_nxt = r_stable;
    case (r_state)
      ST_COUNT: begin
        if (w_s == r_stable) begin
          // Glitch ended before qualifying: forget it.
          w_state_nxt  = ST_IDLE;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_MAX) begin
          w_stable_nxt = w_s;
          w_db_cnt_nxt = '0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      default: begin
        // Counter is 0 in IDLE, so the first differing sample is sample #1.
        if (w_s != r_stable) begin
          if (DB_MAX == '0) begin
            w_stable_nxt = w_s;
          end else begin
            w_state_nxt  = ST_COUNT;
            w_db_cnt_nxt = DB_W'(1);
          end
        end
      end
    endcase
  end

`ifdef EDGE_STROBE_BOTH_EDGES_EN
  assign w_edge = r_stable ^ r_stable_d;
`else
  assign w_edge = r_stable & ~r_stable_d;
`endif

  // A strobe may load the slice when it is empty or being drained this cycle.
  assign w_load = w_edge & (~r_c_valid | c_ready);

  // Strobe, edge counter, output slice and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strb     <= 1'b0;
      r_c        <= '0;
      r_c_valid  <= 1'b0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_strb <= w_edge;
      if (w_edge) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
      if (w_load) begin
        r_c       <= b;
        r_c_valid <= 1'b1;
      end else if (w_edge) begin
        // Slice full and not draining: keep the old word, drop `b`.
        r_ovf <= 1'b1;
      end else if (r_c_valid && c_ready) begin
        r_c_valid <= 1'b0;
      end
    end
  end

  assign strb     = r_strb;
  assign c        = r_c;
  assign c_valid  = r_c_valid;
  assign edge_cnt = r_edge_cnt;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_edge_strobe_sync.sv
// Directed bench for edge_strobe_sync: a main instance with default parameters
// and a CNT_W=2 instance on the same inputs for counter wrap.
// Expected strobe payloads are queued when stimulus is driven and popped on strobe.
module tb_edge_strobe_sync;

  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE    = 4;
  localparam int LAT         = SYNC_STAGES + DEBOUNCE + 1;
`ifdef EDGE_STROBE_BOTH_EDGES_EN
  localparam int EXP_BOTH = 2;
`else
  localparam int EXP_BOTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic [7:0] b;
  logic       c_ready;

  logic       strb;
  logic [7:0] c;
  logic       c_valid;
  logic [7:0] edge_cnt;
  logic       ovf;

  logic       wz_strb;
  logic [7:0] wz_c;
  logic       wz_c_valid;
  logic [1:0] wz_edge_cnt;
  logic       wz_ovf;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_cmp  = 0;
  int n_err  = 0;
  int n_strb = 0;
  int n0;
  int lat;

  logic [7:0] m_c;
  logic [7:0] m_cnt;
  logic       m_valid;
  logic       m_ovf;

  edge_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .strb(strb), .c(c), .c_valid(c_valid),
    .c_ready(c_ready), .edge_cnt(edge_cnt), .ovf(ovf)
  );

  edge_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .W(8), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .strb(wz_strb), .c(wz_c), .c_valid(wz_c_valid),
    .c_ready(c_ready), .edge_cnt(wz_edge_cnt), .ovf(wz_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction-level expectation for one qualified edge given current c_ready.
  function automatic void model_strobe(input logic [7:0] bv);
    exp_t e;
    if (!m_valid || c_ready) begin
      m_c     = bv;
      m_valid = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
    m_cnt = m_cnt + 8'd1;
    e.c   = m_c;
    e.cnt = m_cnt;
    q.push_back(e);
  endfunction

  // Hold `a` high for `hi` samples then low for `lo` samples.
  task automatic pulse(input logic [7:0] bv, input int hi, input int lo);
    b = bv;
    a = 1'b1;
    if (hi >= DEBOUNCE) begin
      model_strobe(bv);
      if (c_ready) m_valid = 1'b0;
    end
`ifdef EDGE_STROBE_BOTH_EDGES_EN
    if (hi >= DEBOUNCE && lo >= DEBOUNCE) begin
      model_strobe(bv);
      if (c_ready) m_valid = 1'b0;
    end
`endif
    cyc(hi);
    a = 1'b0;
    cyc(lo);
  endtask

  task automatic do_reset();
    check("sb_drained", q.size(), 0);
    rst_n   = 1'b0;
    a       = 1'b0;
    b       = 8'h00;
    c_ready = 1'b0;
    m_c     = 8'h00;
    m_cnt   = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    cyc(2);
    check("rst_c_valid", c_valid, 1'b0);
    check("rst_c", c, 8'h00);
    check("rst_edge_cnt", edge_cnt, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    cyc(2);
  endtask

  // Scoreboard: every observed strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (strb === 1'b1) begin
      n_strb++;
      check("sb_strobe_expected", q.size() > 0, 1'b1);
      check("wrap_strb", wz_strb, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_c", c, e.c);
        check("sb_edge_cnt", edge_cnt, e.cnt);
        check("sb_c_valid", c_valid, 1'b1);
        check("sb_wrap_edge_cnt", wz_edge_cnt, e.cnt[1:0]);
      end
    end
  end

  initial begin
    // Reset held with a=1, b=FF: all outputs zero.
    rst_n   = 1'b0;
    a       = 1'b1;
    b       = 8'hFF;
    c_ready = 1'b0;
    m_c     = 8'h00;
    m_cnt   = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    cyc(3);
    check("rst_strb", strb, 1'b0);
    check("rst_c", c, 8'h00);
    check("rst_c_valid", c_valid, 1'b0);
    check("rst_edge_cnt", edge_cnt, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    check("rst_wrap_all", {wz_strb, wz_c, wz_c_valid, wz_edge_cnt, wz_ovf}, 0);

    // Release with a held high: one strobe after edge SYNC_STAGES+DEBOUNCE.
    model_strobe(8'hFF);
    rst_n = 1'b1;
    lat   = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (strb === 1'b1 && lat == 0) lat = i;
    end
    check("latency", lat, LAT);
    cyc(1);
    check("first_strb_once", n_strb, 1);
    check("first_c", c, m_c);
    check("first_edge_cnt", edge_cnt, m_cnt);
    check("first_c_valid", c_valid, m_valid);
    check("first_ovf", ovf, m_ovf);
`ifdef EDGE_STROBE_BOTH_EDGES_EN
    model_strobe(8'hFF);
`endif
    a = 1'b0;
    cyc(12);

    // Drain: c_valid drops, c holds.
    c_ready = 1'b1;
    cyc(1);
    c_ready = 1'b0;
    m_valid = 1'b0;
    check("drain_c_valid", c_valid, m_valid);
    check("drain_c_hold", c, m_c);

    // Glitch rejection: 3 samples ignored, 4 samples qualify.
    do_reset();
    n0 = n_strb;
    pulse(8'h3C, 3, 12);
    check("glitch3_no_strb", n_strb - n0, 0);
    check("glitch3_edge_cnt", edge_cnt, 8'h00);
    pulse(8'h3C, 4, 12);
    check("pulse4_strb", n_strb - n0, m_cnt);
    check("pulse4_edge_cnt", edge_cnt, m_cnt);
    check("pulse4_c", c, m_c);

    // Overflow: two edges with c_ready low; second word dropped.
    do_reset();
    pulse(8'h11, 10, 10);
    pulse(8'h22, 10, 10);
    check("ovf_c", c, m_c);
    check("ovf_c_valid", c_valid, m_valid);
    check("ovf_flag", ovf, m_ovf);
    check("ovf_edge_cnt", edge_cnt, m_cnt);

    // Drain and refill: c_ready high exactly at the capturing edge.
    do_reset();
    pulse(8'h33, 10, 10);
    b = 8'h5A;
    a = 1'b1;
    cyc(6);
    c_ready = 1'b1;
    model_strobe(8'h5A);
    cyc(1);
    c_ready = 1'b0;
    check("refill_strb", strb, 1'b1);
    check("refill_c", c, m_c);
    check("refill_c_valid", c_valid, m_valid);
    check("refill_ovf", ovf, m_ovf);
    cyc(2);

    // Wrap: five edges into the CNT_W=2 instance.
    do_reset();
    c_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      pulse(8'(i), 10, 10);
    end
    check("wrap_final_cnt", wz_edge_cnt, m_cnt[1:0]);
    check("wrap_main_cnt", edge_cnt, m_cnt);

    // Rise then fall, each held 10 cycles.
    do_reset();
    c_ready = 1'b1;
    n0 = n_strb;
    pulse(8'hA5, 10, 10);
    cyc(4);
    check("both_strb_count", n_strb - n0, EXP_BOTH);
    check("both_edge_cnt", edge_cnt, EXP_BOTH);
    check("sb_final_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
